arb8_mux_ctrl: RTL and testbench
================================

ARB8_MUX_CTRL -- requirements
Module: arb8_mux_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum number of beats one grant may carry before it is forcibly released (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  8  per-requester request; bit n high = requester n wants, or is still using, the shared path.
REQ-005 Port: last  input  8  per-requester end-of-burst marker; only the bit of the granted requester is meaningful.
REQ-006 Port: din  input  8  per-requester 1-bit data; bit n = requester n's data.
REQ-007 Port: gnt  output  8  registered one-hot grant; all-zero when no requester is granted.
REQ-008 Port: sel  output  3  registered select for the shared 8:1 path; holds the index of the granted requester.
REQ-009 Port: dout  output  1  registered data from the shared path.
REQ-010 Port: dout_vld  output  1  registered qualifier for dout; high for one cycle per accepted beat.
REQ-011 Port: busy  output  1  high while in state GRANT.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-013 The block SHALL maintain a 3-bit round-robin pointer ptr giving the highest-priority index; priority descends ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-014 In IDLE with req != 0, the block SHALL select the first requester n with req[n]=1 in priority order, load sel=n and gnt=one-hot(n), clear the beat counter, and enter GRANT on the next edge.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE with gnt=0 and leave sel and ptr unchanged.
REQ-016 In GRANT, each cycle with req[sel]=1 SHALL be an accepted beat: on the next edge dout=din[sel], dout_vld=1, and the beat counter increments.
REQ-017 In GRANT, a cycle with req[sel]=0 SHALL abort the burst: no beat, dout_vld=0 on the next edge, release per REQ-019.
REQ-018 In GRANT, the burst SHALL end on a beat with last[sel]=1, or on the beat that brings the beat counter to MAX_HOLD, whichever comes first; that beat is still delivered on dout.
REQ-019 On release (end or abort), the block SHALL set gnt=0, set ptr=sel+1 modulo 8 (index 7 wraps to 0), and enter IDLE on the same edge; sel holds its value.
REQ-020 Arbitration SHALL occur only in IDLE, so there is exactly one idle cycle between consecutive grants; requests arriving in GRANT wait.
REQ-021 Timing: req[n] rising at edge k while in IDLE gives gnt[n]=1 after edge k+1; the first beat is sampled in the cycle after edge k+1, and dout_vld=1 after edge k+2.
REQ-022 dout_vld SHALL be 0 in every cycle that does not immediately follow an accepted beat; dout holds its last value when dout_vld=0.
REQ-023 Changes to req, last or din of non-granted requesters SHALL have no effect during GRANT.
REQ-024 The beat counter SHALL be 8 bits wide and SHALL never exceed MAX_HOLD.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL force state=IDLE, gnt=0, sel=0, ptr=0, dout=0, dout_vld=0, busy=0 and beat counter=0, overriding all other activity.
REQ-026 Reset asserted mid-burst SHALL drop the grant after that edge with no further beats; arbitration resumes from ptr=0 after rst deasserts.

Verification
REQ-027 Single requester: req=0x08, last[3] pulsed on the 3rd beat, din[3]=1,0,1 -> gnt=0x08 and sel=3 one cycle after req; dout=1,0,1 with dout_vld high for 3 cycles; then gnt=0 and ptr=4.
REQ-028 Round-robin fairness: req=0xFF held, each burst of 1 beat (last=0xFF) -> grant order 0,1,2,...,7,0, with one idle cycle between grants.
REQ-029 Wrap and priority: ptr=6, req=0x41 -> requester 6 granted first, then requester 0 (ptr=7 wraps past 7 to 0).
REQ-030 Timeout: MAX_HOLD=4, req=0x02 held, last=0 -> exactly 4 dout_vld pulses, then release and ptr=2; requester 1 is re-granted after one idle cycle.
REQ-031 Abort: requester 5 granted, req[5] drops after 2 beats -> 2 dout_vld pulses, gnt=0 on the next edge, ptr=6.
REQ-032 Reset mid-burst: rst=1 during the 2nd beat of requester 2's burst -> all outputs 0 after that edge; after release, req=0x84 grants requester 2 (ptr=0).

Source files
------------

// File: rtl/arb8_mux_ctrl.sv
// arb8_mux_ctrl: 8-way round-robin arbiter that steers one 1-bit data path.
// A grant carries a burst of beats. The burst ends on the granted requester's
// last marker, on reaching MAX_HOLD beats, or when that requester drops its
// request. Arbitration only happens in IDLE, so two consecutive grants are
// always separated by one idle cycle.
module arb8_mux_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       dout,
  output logic       dout_vld,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_cnt;
  logic [7:0] r_gnt;
  logic [2:0] r_sel;
  logic       r_dout;
  logic       r_vld;

  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_idx;
  logic [7:0] w_cnt_next;
  logic       w_end;

  // Round-robin pick: find the first active request, scanning upward from r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end else begin
        w_found = w_found;
        w_pick  = w_pick;
      end
    end
  end

  // A beat ends the burst on the last marker or when it reaches the hold limit.
  always_comb begin
    w_cnt_next = r_cnt + 8'd1;
    if (last[r_sel] || (w_cnt_next == 8'(MAX_HOLD))) begin
      w_end = 1'b1;
    end else begin
      w_end = 1'b0;
    end
  end

  // Controller state, grant, pointer, beat counter and the registered data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 8'd0;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_dout  <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vld <= 1'b0;
          if (w_found) begin
            r_sel   <= w_pick;
            r_gnt   <= 8'd1 << w_pick;
            r_cnt   <= 8'd0;
            r_state <= ST_GRANT;
          end else begin
            r_gnt <= 8'd0;
          end
        end
        ST_GRANT: begin
          if (req[r_sel]) begin
            // Accepted beat: deliver it, then release if it closes the burst.
            r_dout <= din[r_sel];
            r_vld  <= 1'b1;
            r_cnt  <= w_cnt_next;
            if (w_end) begin
              r_gnt   <= 8'd0;
              r_ptr   <= r_sel + 3'd1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GRANT;
            end
          end else begin
            // Requester dropped out mid-burst: abort without a beat.
            r_vld   <= 1'b0;
            r_gnt   <= 8'd0;
            r_ptr   <= r_sel + 3'd1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 8'd0;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_arb8_mux_ctrl.sv
// Directed testbench for arb8_mux_ctrl, built with MAX_HOLD=4.
// The observed vector is {gnt, sel, busy, dout_vld, dout}.
module tb_arb8_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] last = 8'h00;
  logic [7:0] din = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       dout;
  logic       dout_vld;
  logic       busy;

  int checks = 0;
  int failures = 0;

  arb8_mux_ctrl #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .din(din),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_vld(dout_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; last = 8'h00; din = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'hFF; din = 8'hFF;
    rst = 1'b1;
    step();
    checks++;
    if ({gnt, sel, busy, dout_vld, dout} !== {8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state act=%b exp=%b", {gnt, sel, busy, dout_vld, dout}, 14'b0);
    end
    rst = 1'b0; req = 8'h00; din = 8'h00;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08; din = 8'h08;
    step();
    checks++;
    if ({gnt, sel, busy, dout_vld} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_grant act=%b exp=%b", {gnt, sel, busy, dout_vld}, {8'h08, 3'd3, 1'b1, 1'b0});
    end
    step();
    checks++;
    if ({gnt, dout_vld, dout} !== {8'h08, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_beat1 act=%b exp=%b", {gnt, dout_vld, dout}, {8'h08, 1'b1, 1'b1});
    end
    din = 8'h00;
    step();
    checks++;
    if ({gnt, dout_vld, dout} !== {8'h08, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_beat2 act=%b exp=%b", {gnt, dout_vld, dout}, {8'h08, 1'b1, 1'b0});
    end
    din = 8'h08; last = 8'h08;
    step();
    checks++;
    if ({gnt, sel, busy, dout_vld, dout} !== {8'h00, 3'd3, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_beat3_release act=%b exp=%b", {gnt, sel, busy, dout_vld, dout}, {8'h00, 3'd3, 1'b0, 1'b1, 1'b1});
    end
    req = 8'h00; last = 8'h00;
    step();
    checks++;
    if ({gnt, sel, dout_vld, dout} !== {8'h00, 3'd3, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_idle_hold act=%b exp=%b", {gnt, sel, dout_vld, dout}, {8'h00, 3'd3, 1'b0, 1'b1});
    end
    // Pointer now 4: requester 4 beats requester 3.
    req = 8'h18;
    step();
    checks++;
    if ({gnt, sel} !== {8'h10, 3'd4}) begin
      failures++;
      $display("FAIL single_ptr4 act=%b exp=%b", {gnt, sel}, {8'h10, 3'd4});
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF; last = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step();
      checks++;
      if ({gnt, sel, busy} !== {8'h01 << (g % 8), 3'(g % 8), 1'b1}) begin
        failures++;
        $display("FAIL rr_grant%0d act=%b exp=%b", g, {gnt, sel, busy}, {8'h01 << (g % 8), 3'(g % 8), 1'b1});
      end
      step();
      checks++;
      if ({gnt, busy, dout_vld} !== {8'h00, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL rr_idle%0d act=%b exp=%b", g, {gnt, busy, dout_vld}, {8'h00, 1'b0, 1'b1});
      end
    end
    req = 8'h00; last = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h20; last = 8'h20;
    step();
    step();
    req = 8'h41; last = 8'h41;
    step();
    checks++;
    if ({gnt, sel} !== {8'h40, 3'd6}) begin
      failures++;
      $display("FAIL wrap_first act=%b exp=%b", {gnt, sel}, {8'h40, 3'd6});
    end
    step();
    step();
    checks++;
    if ({gnt, sel} !== {8'h01, 3'd0}) begin
      failures++;
      $display("FAIL wrap_second act=%b exp=%b", {gnt, sel}, {8'h01, 3'd0});
    end
    req = 8'h00; last = 8'h00;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h02; din = 8'h02;
    step();
    for (int b = 1; b <= 4; b++) begin
      step();
      checks++;
      if ({gnt, busy, dout_vld, dout} !== {(b < 4) ? 8'h02 : 8'h00, (b < 4), 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL timeout_beat%0d act=%b exp=%b", b, {gnt, busy, dout_vld, dout}, {(b < 4) ? 8'h02 : 8'h00, (b < 4), 1'b1, 1'b1});
      end
    end
    step();
    checks++;
    if ({gnt, sel, dout_vld} !== {8'h02, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL timeout_regrant act=%b exp=%b", {gnt, sel, dout_vld}, {8'h02, 3'd1, 1'b0});
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    req = 8'h20; din = 8'h20;
    step();
    // Other requesters toggle freely; they must not disturb the burst.
    req = 8'hBF; last = 8'hDF; din = 8'h3F;
    step();
    req = 8'h6F; din = 8'hF0;
    step();
    checks++;
    if ({gnt, dout_vld, dout} !== {8'h20, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL abort_beat2 act=%b exp=%b", {gnt, dout_vld, dout}, {8'h20, 1'b1, 1'b1});
    end
    req = 8'h00; last = 8'h00; din = 8'h00;
    step();
    checks++;
    if ({gnt, busy, dout_vld, dout} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_release act=%b exp=%b", {gnt, busy, dout_vld, dout}, {8'h00, 1'b0, 1'b0, 1'b1});
    end
    req = 8'h60;
    step();
    checks++;
    if ({gnt, sel} !== {8'h40, 3'd6}) begin
      failures++;
      $display("FAIL abort_ptr6 act=%b exp=%b", {gnt, sel}, {8'h40, 3'd6});
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h04; din = 8'h04;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({gnt, sel, busy, dout_vld, dout} !== {8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_state act=%b exp=%b", {gnt, sel, busy, dout_vld, dout}, 14'b0);
    end
    rst = 1'b0; req = 8'h84;
    step();
    checks++;
    if ({gnt, sel, busy} !== {8'h04, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL midreset_regrant act=%b exp=%b", {gnt, sel, busy}, {8'h04, 3'd2, 1'b1});
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
